// File: rtl/ps2_arrow_pkg.sv
// Shared constants, FSM encodings and event payload for the PS/2 arrow-key sequencer.
package ps2_arrow_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef struct packed {
    logic [1:0] dir;
    logic       brk;
  } evt_t;

  function automatic logic is_arrow(input logic [7:0] code);
    case (code)
      SC_UP, SC_LEFT, SC_DOWN, SC_RIGHT: is_arrow = 1'b1;
      default:                           is_arrow = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] arrow_dir(input logic [7:0] code);
    case (code)
      SC_LEFT:  arrow_dir = DIR_LEFT;
      SC_DOWN:  arrow_dir = DIR_DOWN;
      SC_RIGHT: arrow_dir = DIR_RIGHT;
      default:  arrow_dir = DIR_UP;
    endcase
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Event queue with registered valid/head outputs; head holds its last value while empty.
module ps2_evt_fifo
  import ps2_arrow_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic push,
  input  evt_t push_data,
  input  logic pop,
  output logic full_c,
  output logic valid,
  output evt_t head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic          empty_c, do_push, do_pop;
  evt_t          mem [DEPTH];

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty_c;
  assign do_push = push & (~full_c | do_pop);
  assign wr_nxt  = wr_ptr + PW'(do_push);
  assign rd_nxt  = rd_ptr + PW'(do_pop);

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Head is prefetched; a slot not yet in storage is being written this edge, so bypass it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      valid  <= (wr_nxt != rd_nxt);
      if (wr_nxt != rd_nxt) head <= (rd_nxt == wr_ptr) ? push_data : mem[rd_nxt[AW-1:0]];
    end
  end

endmodule

// File: rtl/ps2_arrow_ctrl.sv
// Scan-code sequencer: prefix FSM, arrow held-state, prefix timeout and
// saturating drop/error counters feeding an event FIFO.
module ps2_arrow_ctrl
  import ps2_arrow_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter bit          ACCEPT_KEYPAD  = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BYTE_VALID,
  input  logic [7:0] BYTE_DATA,
  input  logic       BYTE_ERR,
  output logic [3:0] KEY_HELD,
  output logic       EVT_VALID,
  output logic [1:0] EVT_DIR,
  output logic       EVT_BREAK,
  input  logic       EVT_RDY,
  output logic [7:0] DROP_CNT,
  output logic [7:0] ERR_CNT
);

  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state, state_nxt;
  logic [3:0]    held_nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic          arrow_c, kp_arrow_c, press_c, release_c, push_c, drop_c, full_c;
  logic [1:0]    dir_c;
  evt_t          push_evt_c, head;

  assign arrow_c    = is_arrow(BYTE_DATA);
  assign kp_arrow_c = arrow_c & ACCEPT_KEYPAD;
  assign dir_c      = arrow_dir(BYTE_DATA);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state, timeout and held-state update; errors abort any prefix.
  always_comb begin
    state_nxt  = state;
    held_nxt   = KEY_HELD;
    tmo_nxt    = '0;
    press_c    = 1'b0;
    release_c  = 1'b0;
    push_c     = 1'b0;
    push_evt_c = '0;
    if (BYTE_VALID && BYTE_ERR) begin
      state_nxt = ST_IDLE;
    end else if (BYTE_VALID) begin
      case (state)
        ST_IDLE: begin
          if (BYTE_DATA == SC_E0)      state_nxt = ST_EXT;
          else if (BYTE_DATA == SC_F0) state_nxt = ST_BRK;
          else                         press_c   = kp_arrow_c;
        end
        ST_EXT: begin
          state_nxt = (BYTE_DATA == SC_F0) ? ST_EXT_BRK : ST_IDLE;
          press_c   = arrow_c;
        end
        ST_EXT_BRK: begin
          state_nxt = ST_IDLE;
          release_c = arrow_c;
        end
        default: begin
          state_nxt = ST_IDLE;
          release_c = kp_arrow_c;
        end
      endcase
    end else if (state != ST_IDLE) begin
      if (tmo == TMO_LAST) state_nxt = ST_IDLE;
      else                 tmo_nxt   = tmo + TW'(1);
    end
    if (press_c && !KEY_HELD[dir_c]) begin
      held_nxt[dir_c] = 1'b1;
      push_c          = 1'b1;
      push_evt_c      = '{dir: dir_c, brk: 1'b0};
    end
    if (release_c && KEY_HELD[dir_c]) begin
      held_nxt[dir_c] = 1'b0;
      push_c          = 1'b1;
      push_evt_c      = '{dir: dir_c, brk: 1'b1};
    end
  end

  assign drop_c = push_c & full_c & ~(EVT_VALID & EVT_RDY);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      KEY_HELD <= '0;
      tmo      <= '0;
      DROP_CNT <= '0;
      ERR_CNT  <= '0;
    end else begin
      KEY_HELD <= held_nxt;
      tmo      <= tmo_nxt;
      if (drop_c && DROP_CNT != 8'hFF)                   DROP_CNT <= DROP_CNT + 8'd1;
      if (BYTE_VALID && BYTE_ERR && ERR_CNT != 8'hFF)    ERR_CNT  <= ERR_CNT + 8'd1;
    end
  end

  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (push_c),
    .push_data (push_evt_c),
    .pop       (EVT_RDY),
    .full_c    (full_c),
    .valid     (EVT_VALID),
    .head      (head)
  );

  assign EVT_DIR   = head.dir;
  assign EVT_BREAK = head.brk;

endmodule

// File: tb/tb_ps2_arrow_ctrl.sv
// Scoreboard bench: instance a accepts keypad codes, instance b does not; both share stimulus.
module tb_ps2_arrow_ctrl;
  import ps2_arrow_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;

  logic       CLK = 1'b0;
  logic       RESET, BYTE_VALID, BYTE_ERR, EVT_RDY;
  logic [7:0] BYTE_DATA;
  logic [3:0] a_held, b_held;
  logic       a_valid, b_valid, a_brk, b_brk;
  logic [1:0] a_dir, b_dir;
  logic [7:0] a_drop, b_drop, a_err, b_err;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] q_a[$];
  logic [2:0] q_b[$];
  logic [3:0] held_a = 4'b0, held_b = 4'b0;
  int         drop_a = 0, drop_b = 0;

  always #5 CLK = ~CLK;

  ps2_arrow_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .ACCEPT_KEYPAD(1'b1)) dut_a (
    .CLK(CLK), .RESET(RESET), .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA), .BYTE_ERR(BYTE_ERR),
    .KEY_HELD(a_held), .EVT_VALID(a_valid), .EVT_DIR(a_dir), .EVT_BREAK(a_brk), .EVT_RDY(EVT_RDY),
    .DROP_CNT(a_drop), .ERR_CNT(a_err));

  ps2_arrow_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .ACCEPT_KEYPAD(1'b0)) dut_b (
    .CLK(CLK), .RESET(RESET), .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA), .BYTE_ERR(BYTE_ERR),
    .KEY_HELD(b_held), .EVT_VALID(b_valid), .EVT_DIR(b_dir), .EVT_BREAK(b_brk), .EVT_RDY(EVT_RDY),
    .DROP_CNT(b_drop), .ERR_CNT(b_err));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected-event model: a press needs the key released, a release needs it held.
  task automatic key(input bit to_a, input bit to_b, input logic [1:0] dir, input logic brk);
    if (to_a && held_a[dir] == brk) begin
      held_a[dir] = ~brk;
      if (q_a.size() < DEPTH) q_a.push_back({dir, brk});
      else drop_a++;
    end
    if (to_b && held_b[dir] == brk) begin
      held_b[dir] = ~brk;
      if (q_b.size() < DEPTH) q_b.push_back({dir, brk});
      else drop_b++;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic e);
    BYTE_VALID = 1'b1;
    BYTE_DATA  = d;
    BYTE_ERR   = e;
    @(posedge CLK); #1;
    BYTE_VALID = 1'b0;
    BYTE_ERR   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      @(posedge CLK); #1;
    end
    check({name, " pending_a"}, q_a.size(), 0);
    check({name, " pending_b"}, q_b.size(), 0);
  endtask

  always @(negedge CLK) begin
    if (!RESET && EVT_RDY) begin
      if (a_valid) begin
        n_checks++;
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL evt_a: unexpected dir=%0d brk=%0b", a_dir, a_brk);
        end else begin
          logic [2:0] e;
          e = q_a.pop_front();
          if ({a_dir, a_brk} !== e) begin
            n_fail++;
            $display("FAIL evt_a: got dir=%0d brk=%0b expected dir=%0d brk=%0b", a_dir, a_brk, e[2:1], e[0]);
          end
        end
      end
      if (b_valid) begin
        n_checks++;
        if (q_b.size() == 0) begin
          n_fail++;
          $display("FAIL evt_b: unexpected dir=%0d brk=%0b", b_dir, b_brk);
        end else begin
          logic [2:0] e;
          e = q_b.pop_front();
          if ({b_dir, b_brk} !== e) begin
            n_fail++;
            $display("FAIL evt_b: got dir=%0d brk=%0b expected dir=%0d brk=%0b", b_dir, b_brk, e[2:1], e[0]);
          end
        end
      end
    end
  end

  initial begin
    RESET = 1'b1; BYTE_VALID = 1'b0; BYTE_DATA = 8'h00; BYTE_ERR = 1'b0; EVT_RDY = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    check("rst held",  int'(a_held), 0);
    check("rst valid", int'(a_valid), 0);
    check("rst dir",   int'(a_dir), 0);
    check("rst brk",   int'(a_brk), 0);
    check("rst drop",  int'(a_drop), 0);
    check("rst err",   int'(a_err), 0);
    check("rst valid_b", int'(b_valid), 0);

    // Extended up press then release
    send(SC_E0, 0); send(SC_UP, 0); key(1, 1, DIR_UP, 0);
    drain("up_press");
    check("up held_a", int'(a_held), 4'b0001);
    check("up held_b", int'(b_held), 4'b0001);
    send(SC_E0, 0); send(SC_F0, 0); send(SC_UP, 0); key(1, 1, DIR_UP, 1);
    drain("up_rel");
    check("up_rel held_a", int'(a_held), 0);

    // Typematic repeats of left collapse to one press
    repeat (5) begin send(SC_E0, 0); send(SC_LEFT, 0); key(1, 1, DIR_LEFT, 0); end
    drain("typematic");
    check("typematic held_a", int'(a_held), 4'b0010);
    check("typematic held_b", int'(b_held), 4'b0010);
    send(SC_E0, 0); send(SC_F0, 0); send(SC_LEFT, 0); key(1, 1, DIR_LEFT, 1);
    drain("left_rel");

    // Error after E0 aborts the prefix; 74 is then a keypad code
    send(SC_E0, 0); send(SC_F0, 1); send(SC_RIGHT, 0); key(1, 0, DIR_RIGHT, 0);
    drain("err");
    check("err cnt_a", int'(a_err), 1);
    check("err cnt_b", int'(b_err), 1);
    check("err held_a", int'(a_held), 4'b1000);
    check("err held_b", int'(b_held), 4'b0000);
    send(SC_E0, 0); send(SC_F0, 0); send(SC_RIGHT, 0); key(1, 1, DIR_RIGHT, 1);
    drain("right_rel");

    // Plain keypad press/release
    send(SC_DOWN, 0); key(1, 0, DIR_DOWN, 0);
    check("kp held_a", int'(a_held), 4'b0100);
    check("kp held_b", int'(b_held), 4'b0000);
    send(SC_F0, 0); send(SC_DOWN, 0); key(1, 0, DIR_DOWN, 1);
    drain("keypad");
    check("kp_rel held_a", int'(a_held), 0);

    // Prefix survives just under the timeout
    send(SC_E0, 0); idle(14); send(SC_UP, 0); key(1, 1, DIR_UP, 0);
    drain("no_timeout");
    check("no_tmo held_b", int'(b_held), 4'b0001);
    send(SC_E0, 0); send(SC_F0, 0); send(SC_UP, 0); key(1, 1, DIR_UP, 1);
    drain("up_rel2");

    // Abandoned E0 times out, so F0 72 is a plain (keypad) break
    send(SC_E0, 0); send(SC_DOWN, 0); key(1, 1, DIR_DOWN, 0);
    send(SC_E0, 0); idle(20); send(SC_F0, 0); send(SC_DOWN, 0); key(1, 0, DIR_DOWN, 1);
    drain("timeout");
    check("tmo held_a", int'(a_held), 4'b0000);
    check("tmo held_b", int'(b_held), 4'b0100);
    send(SC_E0, 0); send(SC_F0, 0); send(SC_DOWN, 0); key(1, 1, DIR_DOWN, 1);
    drain("down_rel");
    check("tmo_rel held_b", int'(b_held), 0);

    // Overflow: six events into a four-deep queue
    EVT_RDY = 1'b0;
    send(SC_E0, 0); send(SC_UP, 0);    key(1, 1, DIR_UP, 0);
    send(SC_E0, 0); send(SC_LEFT, 0);  key(1, 1, DIR_LEFT, 0);
    send(SC_E0, 0); send(SC_DOWN, 0);  key(1, 1, DIR_DOWN, 0);
    send(SC_E0, 0); send(SC_RIGHT, 0); key(1, 1, DIR_RIGHT, 0);
    send(SC_E0, 0); send(SC_F0, 0); send(SC_UP, 0);   key(1, 1, DIR_UP, 1);
    send(SC_E0, 0); send(SC_F0, 0); send(SC_LEFT, 0); key(1, 1, DIR_LEFT, 1);
    idle(2);
    check("ovf drop_a", int'(a_drop), 2);
    check("ovf drop_b", int'(b_drop), 2);
    check("ovf drop_model", drop_a, 2);
    check("ovf valid_a", int'(a_valid), 1);
    check("ovf held_a", int'(a_held), 4'b1100);
    EVT_RDY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("burst valid_a", int'(a_valid), 1);
    end
    @(negedge CLK);
    check("burst empty_a", int'(a_valid), 0);
    @(posedge CLK); #1;
    drain("burst");
    send(SC_E0, 0); send(SC_F0, 0); send(SC_DOWN, 0);  key(1, 1, DIR_DOWN, 1);
    send(SC_E0, 0); send(SC_F0, 0); send(SC_RIGHT, 0); key(1, 1, DIR_RIGHT, 1);
    drain("ovf_rel");
    check("ovf_rel held_a", int'(a_held), 0);

    // Asynchronous reset while in EXT_BRK with two queued events
    EVT_RDY = 1'b0;
    send(SC_E0, 0); send(SC_UP, 0);   key(1, 1, DIR_UP, 0);
    send(SC_E0, 0); send(SC_LEFT, 0); key(1, 1, DIR_LEFT, 0);
    send(SC_E0, 0); send(SC_F0, 0);
    check("pre_rst valid_a", int'(a_valid), 1);
    #1 RESET = 1'b1;
    #1;
    check("arst held_a",  int'(a_held), 0);
    check("arst valid_a", int'(a_valid), 0);
    check("arst dir_a",   int'(a_dir), 0);
    check("arst brk_a",   int'(a_brk), 0);
    check("arst drop_a",  int'(a_drop), 0);
    check("arst err_a",   int'(a_err), 0);
    check("arst valid_b", int'(b_valid), 0);
    check("arst held_b",  int'(b_held), 0);
    q_a.delete(); q_b.delete();
    held_a = 4'b0; held_b = 4'b0;
    @(posedge CLK); #1;
    RESET = 1'b0; EVT_RDY = 1'b1;
    send(SC_E0, 0); send(SC_UP, 0); key(1, 1, DIR_UP, 0);
    drain("post_rst");
    check("post_rst held_a", int'(a_held), 4'b0001);
    check("post_rst held_b", int'(b_held), 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
